// File: rtl/lampfpu_f2i_round.sv
// rtl/lampfpu_f2i_round.sv - float-to-integer rounding, negation and saturation back end
module lampfpu_f2i_round #(
  parameter int INT_DW = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              s_i,
  input  logic [INT_DW+2:0] f_i,
  input  logic              isOverflow_i,
  input  logic              isNaN_i,
  input  logic [2:0]        rnd_mode_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [INT_DW-1:0] res_o,
  output logic              nv_o,
  output logic              nx_o
);

  localparam logic [2:0] RNE = 3'd0;
  localparam logic [2:0] RDN = 3'd2;
  localparam logic [2:0] RUP = 3'd3;
  localparam logic [2:0] RMM = 3'd4;

  // Saturation limits, and the largest legal rounded magnitude per sign
  localparam logic [INT_DW-1:0] LIM_POS = {1'b0, {(INT_DW-1){1'b1}}};
  localparam logic [INT_DW-1:0] LIM_NEG = {1'b1, {(INT_DW-1){1'b0}}};
  localparam logic [INT_DW:0]   MAX_POS = {2'b00, {(INT_DW-1){1'b1}}};
  localparam logic [INT_DW:0]   MAX_NEG = {2'b01, {(INT_DW-1){1'b0}}};

  // Bit 0 of the fraction carries no information for rounding
  logic unused_f0;
  assign unused_f0 = f_i[0];

  logic              adv;
  logic              s1_valid;
  logic              s1_s;
  logic [INT_DW+2:1] s1_f;
  logic              s1_ovf;
  logic              s1_nan;
  logic [2:0]        s1_rm;

  logic [INT_DW-1:0] mag;
  logic              g;
  logic              st;
  logic              inc;
  logic [INT_DW:0]   rmag;
  logic              range_err;
  logic [INT_DW-1:0] res_n;
  logic              nv_n;
  logic              nx_n;

  // Whole pipeline moves together whenever the output slot is free or being taken
  assign adv     = ~valid_o | ready_i;
  assign ready_o = adv;

  // Rounding decision, carry-preserving increment, range check and result selection
  always_comb begin
    mag       = s1_f[INT_DW+2:3];
    g         = s1_f[2];
    st        = s1_f[1];
    inc       = 1'b0;
    case (s1_rm)
      RNE:     inc = g & (st | mag[0]);
      RDN:     inc = s1_s & (g | st);
      RUP:     inc = ~s1_s & (g | st);
      RMM:     inc = g;
      default: inc = 1'b0;
    endcase
    rmag      = {1'b0, mag} + {{INT_DW{1'b0}}, inc};
    range_err = s1_s ? (rmag > MAX_NEG) : (rmag > MAX_POS);
    res_n     = s1_s ? -rmag[INT_DW-1:0] : rmag[INT_DW-1:0];
    nv_n      = 1'b0;
    nx_n      = g | st;
    if (s1_nan) begin
      res_n = LIM_POS;
      nv_n  = 1'b1;
      nx_n  = 1'b0;
    end else if (s1_ovf || range_err) begin
      res_n = s1_s ? LIM_NEG : LIM_POS;
      nv_n  = 1'b1;
      nx_n  = 1'b0;
    end
  end

  // Stage 1: capture the operand; flush drops it without touching the data
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_s     <= 1'b0;
      s1_f     <= '0;
      s1_ovf   <= 1'b0;
      s1_nan   <= 1'b0;
      s1_rm    <= '0;
    end else if (flush_i) begin
      s1_valid <= 1'b0;
    end else if (adv) begin
      s1_valid <= valid_i;
      if (valid_i) begin
        s1_s   <= s_i;
        s1_f   <= f_i[INT_DW+2:1];
        s1_ovf <= isOverflow_i;
        s1_nan <= isNaN_i;
        s1_rm  <= rnd_mode_i;
      end
    end
  end

  // Stage 2: register the rounded result and flags
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_o <= 1'b0;
      res_o   <= '0;
      nv_o    <= 1'b0;
      nx_o    <= 1'b0;
    end else if (flush_i) begin
      valid_o <= 1'b0;
    end else if (adv) begin
      valid_o <= s1_valid;
      if (s1_valid) begin
        res_o <= res_n;
        nv_o  <= nv_n;
        nx_o  <= nx_n;
      end
    end
  end

endmodule

// File: tb/tb_lampfpu_f2i_round.sv
// tb/tb_lampfpu_f2i_round.sv - scoreboard bench for lampfpu_f2i_round
module tb_lampfpu_f2i_round;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic        s_i = 1'b0;
  logic [34:0] f_i = '0;
  logic        isOverflow_i = 1'b0;
  logic        isNaN_i = 1'b0;
  logic [2:0]  rnd_mode_i = '0;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic [31:0] res_o;
  logic        nv_o;
  logic        nx_o;

  int applied = 0;
  int miscompares = 0;
  logic [33:0] exp_q[$];
  logic [33:0] hold_val;
  logic        hold_v = 1'b0;

  lampfpu_f2i_round #(.INT_DW(32)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .s_i(s_i), .f_i(f_i), .isOverflow_i(isOverflow_i), .isNaN_i(isNaN_i),
    .rnd_mode_i(rnd_mode_i), .valid_o(valid_o), .ready_i(ready_i),
    .res_o(res_o), .nv_o(nv_o), .nx_o(nx_o)
  );

  always #5 clk = ~clk;

  function automatic logic [34:0] mk_f(input logic [31:0] mag, input logic g, input logic st);
    return {mag, g, st, 1'b0};
  endfunction

  task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Drive one operand at a negedge, retry until accepted, push its expectation
  task automatic send(input logic s, input logic [34:0] f, input logic ovf, input logic nan,
                      input logic [2:0] rm, input logic [31:0] er, input logic env, input logic enx);
    int tries = 0;
    @(negedge clk);
    s_i = s; f_i = f; isOverflow_i = ovf; isNaN_i = nan; rnd_mode_i = rm; valid_i = 1'b1;
    #1;
    while (!ready_o && tries < 50) begin
      @(negedge clk);
      #1;
      tries++;
    end
    if (!ready_o) begin
      applied++;
      miscompares++;
      $display("FAIL accept_timeout: ready_o stuck at %b want 1", ready_o);
    end else begin
      exp_q.push_back({er, env, enx});
    end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  // Monitor: sample before the coming posedge, pop on handshake, check stall stability
  always @(negedge clk) begin
    #2;
    if (!rst && !flush_i && valid_o && ready_i) begin
      hold_v = 1'b0;
      if (exp_q.size() == 0) begin
        applied++;
        miscompares++;
        $display("FAIL unexpected_result: got %h want none", {res_o, nv_o, nx_o});
      end else begin
        chk("result", {res_o, nv_o, nx_o}, exp_q.pop_front());
      end
    end else if (!rst && !flush_i && valid_o && !ready_i) begin
      if (hold_v) chk("stall_hold", {res_o, nv_o, nx_o}, hold_val);
      hold_val = {res_o, nv_o, nx_o};
      hold_v   = 1'b1;
    end else begin
      hold_v = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time %0t exceeded", $time);
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_state", {res_o, nv_o, nx_o}, 34'd0);
    chk("reset_valid_ready", {32'd0, valid_o, ready_o}, {32'd0, 1'b0, 1'b1});

    // RNE ties
    send(0, mk_f(32'd5, 1, 0), 0, 0, 3'd0, 32'd6, 0, 1);
    send(0, mk_f(32'd4, 1, 0), 0, 0, 3'd0, 32'd4, 0, 1);
    send(0, mk_f(32'd4, 0, 0), 0, 0, 3'd0, 32'd4, 0, 0);
    // Directed modes on -2.5
    send(1, mk_f(32'd2, 1, 0), 0, 0, 3'd2, 32'hFFFFFFFD, 0, 1);
    send(1, mk_f(32'd2, 1, 0), 0, 0, 3'd3, 32'hFFFFFFFE, 0, 1);
    send(1, mk_f(32'd2, 1, 0), 0, 0, 3'd1, 32'hFFFFFFFE, 0, 1);
    send(1, mk_f(32'd2, 1, 0), 0, 0, 3'd4, 32'hFFFFFFFD, 0, 1);
    // Sticky only, and reserved mode behaving as RTZ
    send(0, mk_f(32'd3, 0, 1), 0, 0, 3'd0, 32'd3, 0, 1);
    send(0, mk_f(32'd3, 0, 1), 0, 0, 3'd3, 32'd4, 0, 1);
    send(0, mk_f(32'd9, 1, 1), 0, 0, 3'd6, 32'd9, 0, 1);
    // Saturation and range boundaries
    send(0, mk_f(32'h7FFFFFFF, 1, 0), 0, 0, 3'd3, 32'h7FFFFFFF, 1, 0);
    send(1, mk_f(32'h80000000, 0, 0), 0, 0, 3'd0, 32'h80000000, 0, 0);
    send(1, mk_f(32'h80000000, 1, 0), 0, 0, 3'd0, 32'h80000000, 0, 1);
    send(1, mk_f(32'h80000000, 0, 1), 0, 0, 3'd2, 32'h80000000, 1, 0);
    send(1, mk_f(32'hFFFFFFFF, 1, 0), 0, 0, 3'd0, 32'h80000000, 1, 0);
    send(1, mk_f(32'd7, 1, 1), 1, 0, 3'd0, 32'h80000000, 1, 0);
    send(0, mk_f(32'h12345678, 1, 1), 0, 1, 3'd3, 32'h7FFFFFFF, 1, 0);
    idle();
    repeat (4) @(negedge clk);
    chk("drain_basic", 34'(exp_q.size()), 34'd0);

    // Back-pressure: 4 operands, ready_i low from cycle 2
    fork
      begin
        send(0, mk_f(32'd100, 0, 0), 0, 0, 3'd0, 32'd100, 0, 0);
        send(1, mk_f(32'd101, 0, 0), 0, 0, 3'd0, 32'hFFFFFF9B, 0, 0);
        send(0, mk_f(32'd102, 1, 1), 0, 0, 3'd1, 32'd102, 0, 1);
        send(0, mk_f(32'd103, 1, 0), 0, 0, 3'd4, 32'd104, 0, 1);
        idle();
      end
      begin
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        ready_i = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("stall_ready_valid", {32'd0, ready_o, valid_o}, {32'd0, 1'b0, 1'b1});
        @(negedge clk);
        ready_i = 1'b1;
      end
    join
    repeat (6) @(negedge clk);
    chk("drain_backpressure", 34'(exp_q.size()), 34'd0);

    // Flush with two entries in flight
    @(negedge clk);
    ready_i = 1'b0;
    send(0, mk_f(32'd55, 0, 0), 0, 0, 3'd0, 32'd55, 0, 0);
    send(0, mk_f(32'd56, 0, 0), 0, 0, 3'd0, 32'd56, 0, 0);
    @(negedge clk);
    valid_i = 1'b0;
    flush_i = 1'b1;
    exp_q.delete();
    @(negedge clk);
    flush_i = 1'b0;
    ready_i = 1'b1;
    #2;
    chk("flush_valid", {33'd0, valid_o}, 34'd0);
    send(0, mk_f(32'd77, 1, 0), 0, 0, 3'd3, 32'd78, 0, 1);
    @(negedge clk);
    valid_i = 1'b0;
    #2;
    chk("latency_cycle1", {33'd0, valid_o}, 34'd0);
    @(negedge clk);
    #2;
    chk("latency_cycle2", {33'd0, valid_o}, 34'd1);
    repeat (3) @(negedge clk);
    chk("drain_flush", 34'(exp_q.size()), 34'd0);

    // Reset mid-stream, asserted together with flush
    send(0, mk_f(32'd11, 0, 0), 0, 0, 3'd0, 32'd11, 0, 0);
    send(0, mk_f(32'd12, 0, 0), 0, 0, 3'd0, 32'd12, 0, 0);
    @(negedge clk);
    valid_i = 1'b0;
    rst = 1'b1;
    flush_i = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    flush_i = 1'b0;
    #1;
    chk("rst_outputs", {res_o, nv_o, nx_o}, 34'd0);
    chk("rst_valid_ready", {32'd0, valid_o, ready_o}, {32'd0, 1'b0, 1'b1});
    repeat (3) @(negedge clk);
    #3;
    chk("rst_no_partial", {33'd0, valid_o}, 34'd0);

    send(1, mk_f(32'd6, 1, 0), 0, 0, 3'd0, 32'hFFFFFFFA, 0, 1);
    idle();
    repeat (4) @(negedge clk);
    chk("drain_final", 34'(exp_q.size()), 34'd0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
